// File: rtl/irq_request_latch.sv
// Request-capture stage feeding priority_encoder: edge-detects request lines into
// sticky pending bits, masks them and presents a frozen snapshot until acknowledged.
module irq_request_latch #(
    parameter int N      = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      irq_in,
    input  logic              mask_we,
    input  logic [N-1:0]      mask_in,
    output logic [N-1:0]      req_out,
    output logic              irq_valid,
    input  logic              ack,
    input  logic [CODE_W-1:0] ack_code,
    output logic [N-1:0]      pending,
    output logic [N-1:0]      overrun,
    output logic              bad_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [N-1:0] irq_prev_reg;
    logic [N-1:0] pending_reg, pending_next;
    logic [N-1:0] overrun_reg, overrun_next;
    logic [N-1:0] mask_reg;
    logic [N-1:0] req_reg, req_next;
    logic         valid_reg;
    logic         bad_ack_reg, bad_ack_next;

    logic [N-1:0] rise;
    logic [N-1:0] ack_sel;
    logic [N-1:0] clr;
    logic         ack_hit;

    assign rise = irq_in & ~irq_prev_reg;

    // One-hot decode of ack_code; a code beyond N-1 selects nothing, so it
    // can never hit the snapshot and is reported as a bad ack.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign ack_sel[gi]      = (ack_code == CODE_W'(gi));
            // A new edge wins over a same-cycle clear; the clear still wipes overrun.
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
            assign overrun_next[gi] = ~clr[gi] & (overrun_reg[gi] | (rise[gi] & pending_reg[gi]));
        end
    endgenerate

    assign ack_hit = |(ack_sel & req_reg);

    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        bad_ack_next = 1'b0;
        clr          = '0;
        case (state_reg)
            IDLE: begin
                if ((pending_reg & ~mask_reg) != '0) begin
                    req_next   = pending_reg & ~mask_reg;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    if (ack_hit) begin
                        clr        = ack_sel;
                        state_next = HOLD;
                    end else begin
                        bad_ack_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                req_next   = '0;
                state_next = IDLE;
            end
            default: begin
                req_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            irq_prev_reg <= '0;
            pending_reg  <= '0;
            overrun_reg  <= '0;
            mask_reg     <= '0;
            req_reg      <= '0;
            valid_reg    <= 1'b0;
            bad_ack_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            irq_prev_reg <= irq_in;
            pending_reg  <= pending_next;
            overrun_reg  <= overrun_next;
            if (mask_we) begin
                mask_reg <= mask_in;
            end
            req_reg      <= req_next;
            valid_reg    <= (state_next == REQ);
            bad_ack_reg  <= bad_ack_next;
        end
    end

    assign req_out   = req_reg;
    assign irq_valid = valid_reg;
    assign pending   = pending_reg;
    assign overrun   = overrun_reg;
    assign bad_ack   = bad_ack_reg;

endmodule

// File: tb/tb_irq_request_latch.sv
// Table-driven bench for irq_request_latch: each row is one clock of stimulus with
// the outputs expected after that edge, routed through a scoreboard queue.
module tb_irq_request_latch;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_in;
    logic [7:0] req_out;
    logic       irq_valid;
    logic       ack;
    logic [2:0] ack_code;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic       bad_ack;

    int n_checks = 0;
    int n_fail   = 0;

    irq_request_latch #(.N(8), .CODE_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .mask_we  (mask_we),
        .mask_in  (mask_in),
        .req_out  (req_out),
        .irq_valid(irq_valid),
        .ack      (ack),
        .ack_code (ack_code),
        .pending  (pending),
        .overrun  (overrun),
        .bad_ack  (bad_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mask;
        logic       ack;
        logic [2:0] code;
        logic [7:0] pend;
        logic [7:0] ovr;
        logic [7:0] req;
        logic       val;
        logic       bad;
    } vec_t;

    typedef struct {
        int         row;
        logic [7:0] pend;
        logic [7:0] ovr;
        logic [7:0] req;
        logic       val;
        logic       bad;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic t(input logic r, input logic [7:0] irq, input logic mwe, input logic [7:0] mask,
                     input logic a, input logic [2:0] code,
                     input logic [7:0] pend, input logic [7:0] ovr, input logic [7:0] req,
                     input logic val, input logic bad);
        vec_t v;
        v.rst = r; v.irq = irq; v.mwe = mwe; v.mask = mask; v.ack = a; v.code = code;
        v.pend = pend; v.ovr = ovr; v.req = req; v.val = val; v.bad = bad;
        vecs.push_back(v);
    endtask

    task automatic chk8(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %02h expected %02h", name, row, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int row, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0b expected %0b", name, row, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   cycles;

        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_in = '0; ack = 1'b0; ack_code = '0;

        //  rst irq    mwe mask   ack code  pend   ovr    req    val  bad
        // Basic capture, ack, no re-request while line stays high
        t(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h04, 0, 8'h00, 0, 3'd0, 8'h04, 8'h00, 8'h00, 0, 0);
        t(0, 8'h04, 0, 8'h00, 0, 3'd0, 8'h04, 8'h00, 8'h04, 1, 0);
        t(0, 8'h04, 0, 8'h00, 1, 3'd2, 8'h00, 8'h00, 8'h04, 0, 0);
        t(0, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        // Mask bit7, simultaneous rises, unmask releases the held line
        t(0, 8'h00, 1, 8'h80, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h82, 0, 8'h00, 0, 3'd0, 8'h82, 8'h00, 8'h00, 0, 0);
        t(0, 8'h82, 0, 8'h00, 0, 3'd0, 8'h82, 8'h00, 8'h02, 1, 0);
        t(0, 8'h82, 0, 8'h00, 1, 3'd1, 8'h80, 8'h00, 8'h02, 0, 0);
        t(0, 8'h82, 1, 8'h00, 0, 3'd0, 8'h80, 8'h00, 8'h00, 0, 0);
        t(0, 8'h82, 0, 8'h00, 0, 3'd0, 8'h80, 8'h00, 8'h80, 1, 0);
        t(0, 8'h82, 0, 8'h00, 1, 3'd7, 8'h00, 8'h00, 8'h80, 0, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        // Overrun on bit4, bad ack, good ack clears overrun
        t(0, 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h00, 8'h00, 0, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h10, 8'h00, 8'h10, 1, 0);
        t(0, 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 8'h10, 1, 0);
        t(0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h10, 8'h10, 8'h10, 1, 1);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 8'h10, 1, 0);
        t(0, 8'h00, 0, 8'h00, 1, 3'd4, 8'h00, 8'h00, 8'h10, 0, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        // Collision: rise on bit0 with its own ack; set wins, overrun cleared
        t(0, 8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h00, 8'h00, 0, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h01, 8'h00, 8'h01, 1, 0);
        t(0, 8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h01, 8'h01, 1, 0);
        t(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h01, 8'h01, 8'h01, 1, 0);
        t(0, 8'h01, 0, 8'h00, 1, 3'd0, 8'h01, 8'h00, 8'h01, 0, 0);
        t(0, 8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h00, 8'h00, 0, 0);
        t(0, 8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h00, 8'h01, 1, 0);
        // Reset mid-handshake with ack; lines high at release give fresh edges
        t(0, 8'h11, 0, 8'h00, 0, 3'd0, 8'h11, 8'h00, 8'h01, 1, 0);
        t(1, 8'h11, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h11, 0, 8'h00, 0, 3'd0, 8'h11, 8'h00, 8'h00, 0, 0);
        t(0, 8'h11, 0, 8'h00, 0, 3'd0, 8'h11, 8'h00, 8'h11, 1, 0);
        // Frozen snapshot: new edge and mask write during REQ leave req_out alone
        t(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h00, 8'h00, 0, 0);
        t(0, 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h00, 8'h10, 1, 0);
        t(0, 8'h90, 1, 8'h10, 0, 3'd0, 8'h90, 8'h00, 8'h10, 1, 0);
        t(0, 8'h90, 0, 8'h00, 1, 3'd4, 8'h80, 8'h00, 8'h10, 0, 0);
        t(0, 8'h90, 0, 8'h00, 0, 3'd0, 8'h80, 8'h00, 8'h00, 0, 0);
        t(0, 8'h90, 0, 8'h00, 0, 3'd0, 8'h80, 8'h00, 8'h80, 1, 0);
        t(0, 8'h90, 0, 8'h00, 1, 3'd7, 8'h00, 8'h00, 8'h80, 0, 0);
        // Ack in HOLD and IDLE is ignored
        t(0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
        t(0, 8'h00, 0, 8'h00, 1, 3'd3, 8'h00, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            irq_in   = vecs[i].irq;
            mask_we  = vecs[i].mwe;
            mask_in  = vecs[i].mask;
            ack      = vecs[i].ack;
            ack_code = vecs[i].code;
            e.row = i; e.pend = vecs[i].pend; e.ovr = vecs[i].ovr; e.req = vecs[i].req;
            e.val = vecs[i].val; e.bad = vecs[i].bad;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            $display("row %0d: irq=%02h ack=%0b/%0d -> pend=%02h ovr=%02h req=%02h val=%0b bad=%0b",
                     e.row, irq_in, ack, ack_code, pending, overrun, req_out, irq_valid, bad_ack);
            chk8("pending", e.row, pending, e.pend);
            chk8("overrun", e.row, overrun, e.ovr);
            chk8("req_out", e.row, req_out, e.req);
            chk1("irq_valid", e.row, irq_valid, e.val);
            chk1("bad_ack", e.row, bad_ack, e.bad);
        end

        // Hand sequence: single-cycle pulse latency measured with a bounded wait
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; ack = 1'b0; ack_code = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk8("post_reset_pending", 100, pending, 8'h00);
        irq_in = 8'h08;
        e.row = 101; e.pend = 8'h08; e.ovr = 8'h00; e.req = 8'h08; e.val = 1'b1; e.bad = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        irq_in = 8'h00;
        cycles = 1;
        while (!irq_valid && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        e = sb.pop_front();
        $display("pulse: irq_valid after %0d edges, req=%02h pend=%02h", cycles, req_out, pending);
        chk1("pulse_valid", e.row, irq_valid, e.val);
        chk8("pulse_latency", e.row, 8'(cycles), 8'd2);
        chk8("pulse_req", e.row, req_out, e.req);
        chk8("pulse_pending", e.row, pending, e.pend);

        ack = 1'b1; ack_code = 3'd3;
        @(posedge clk);
        #1;
        ack = 1'b0;
        $display("pulse ack: val=%0b bad=%0b pend=%02h", irq_valid, bad_ack, pending);
        chk1("pulse_ack_valid", 102, irq_valid, 1'b0);
        chk1("pulse_ack_bad", 102, bad_ack, 1'b0);
        chk8("pulse_ack_pending", 102, pending, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk1("pulse_no_rerequest", 103 + k, irq_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Request-capture stage that sits directly upstream of `priority_encoder`.
- Detects rising edges on 8 request lines, holds them as sticky pending bits and applies a software mask.
- Presents a frozen, masked request vector to the encoder. Encoder output `code` returns as `ack_code`.
- Handshakes with the consumer and clears the acknowledged pending bit.

Parameters:
- N, 8, number of request lines (encoder input width).
- CODE_W, 3, width of ack_code; must equal clog2(N).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  N  raw request lines, level; rising edge = new event.
- mask_we  input  1  write strobe for mask register.
- mask_in  input  N  new mask value; bit=1 blocks that line.
- req_out  output  N  frozen masked request vector to priority_encoder input.
- irq_valid  output  1  req_out is valid and awaiting ack.
- ack  input  1  consumer acknowledges the line named by ack_code.
- ack_code  input  CODE_W  index being acknowledged (encoder `code`).
- pending  output  N  raw sticky pending register, unmasked.
- overrun  output  N  sticky per-bit flag: edge arrived while bit already pending.
- bad_ack  output  1  one-cycle pulse: ack with index not set in req_out.

Behaviour:
- Reset (synchronous, rst=1 at rising clk):
  - pending, overrun, mask, req_out, irq_prev = 0.
  - irq_valid = 0, bad_ack = 0, state = IDLE.
  - rst overrides all other inputs in the same cycle, including mid-handshake: a snapshot is discarded and no ack is honoured.
- Edge detect:
  - rise[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle.
  - A line already high when rst releases produces an edge on the first cycle out of reset.
- Pending set:
  - rise[i] sets pending[i] next edge, regardless of mask and FSM state.
  - rise[i] while pending[i]=1 (and not cleared this cycle) sets overrun[i].
- Mask:
  - mask_we=1 loads mask next edge; affects IDLE evaluation from the following cycle.
  - Never alters a snapshot already in req_out.
- FSM, 3 states:
  - IDLE: irq_valid=0. If (pending & ~mask) != 0, then req_out <= pending & ~mask and go to REQ.
  - REQ: irq_valid=1; req_out held constant.
    - On ack=1 with req_out[ack_code]=1: clear pending[ack_code] and overrun[ack_code], then go to HOLD.
    - On ack=1 with req_out[ack_code]=0: no state change, bad_ack=1 for one cycle, stay in REQ.
  - HOLD: irq_valid=0, req_out <= 0, go to IDLE. Guarantees a one-cycle deassert gap between requests.
- Latency:
  - irq_in rise sampled at edge k: pending set after k, irq_valid=1 after k+1.
  - Ack at edge m: irq_valid=0 after m; earliest next irq_valid after m+2.
- ack in IDLE/HOLD: ignored, no bad_ack.
- Simultaneous rise[i] and valid ack clearing bit i: set wins, pending[i] stays 1, overrun[i] not set, overrun[i] cleared.
- Edges on other bits during REQ: latch into pending, but are not visible in req_out until the next IDLE pass.
- ack_code >= N when N < 2^CODE_W: treated as bad_ack.
- X/Z on irq_in is outside contract; no defined response required.
- req_out, irq_valid, bad_ack are registered outputs (no combinational input-to-output paths).

Test Plan:
- Reset then irq_in=8'b00000100 held from cycle 1:
  - pending=8'h04 after edge 1; irq_valid=1 and req_out=8'h04 after edge 2.
  - ack=1, ack_code=3'd2 → pending=0, irq_valid=0 next edge, no re-request since line stays high.
- Mask and simultaneous rises:
  - mask=8'h80; irq_in 0→8'b10000010 in one cycle → req_out=8'h02 (bit7 pending but masked); pending=8'h82.
  - Ack code 1, then mask_we with mask_in=0 → after HOLD/IDLE, req_out=8'h80, irq_valid=1.
- Overrun and bad ack:
  - Pulse irq_in[4] twice (low between) before any ack → pending[4]=1, overrun=8'h10.
  - ack_code=3'd0 → bad_ack pulse, state stays REQ.
  - ack_code=3'd4 → overrun=0.
- Collision: in REQ with req_out=8'h01, pulse irq_in[0] rising in the same cycle as ack, code 0 → pending[0]=1, overrun[0]=0; irq_valid re-asserts with req_out=8'h01 two cycles after HOLD.
- Reset mid-handshake: irq_valid=1, pending=8'h11, assert rst with ack=1 → all outputs 0 next edge; no bad_ack.
- Frozen snapshot: in REQ with req_out=8'h10, raise irq_in[7] → pending=8'h90 but req_out stays 8'h10 until ack; next request shows 8'h80.
